// File: rtl/mul_arb_pkg.sv
// Shared types for the two-port multiplier arbiter: FSM states, default widths
// and the round-robin pointer encoding.
package mul_arb_pkg;

  localparam int MUL_DEFAULT_DATA_W      = 32;
  localparam int MUL_DEFAULT_WDOG_CYCLES = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  // The pointer records the requester served last; the other one wins a tie.
  typedef enum logic {
    PTR_LAST0 = 1'b0,
    PTR_LAST1 = 1'b1
  } rr_ptr_t;

  localparam rr_ptr_t PTR_RESET = PTR_LAST1;

  function automatic rr_ptr_t ptr_from_grant(input logic [1:0] gnt);
    return gnt[1] ? PTR_LAST1 : PTR_LAST0;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant from a request pair and the
// last-served pointer.
module rr_pick2
  import mul_arb_pkg::*;
(
  input  logic [1:0] req,
  input  rr_ptr_t    ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == PTR_LAST1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one shared multiplier (clear/run/wait handshake).
// Define MUL_ARB_WATCHDOG_EN to add a WAIT-state timeout that reports err0/err1.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int DATA_W      = MUL_DEFAULT_DATA_W,
  parameter int WDOG_CYCLES = MUL_DEFAULT_WDOG_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [DATA_W-1:0]   a0,
  input  logic [DATA_W-1:0]   b0,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   b1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [2*DATA_W-1:0] prod0,
  output logic [2*DATA_W-1:0] prod1,
  output logic                err0,
  output logic                err1,
  output logic                busy,
  output logic                mul_clr,
  output logic                mul_run,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic                mul_ready,
  input  logic [2*DATA_W-1:0] mul_product
);

  arb_state_t state, next_state;
  rr_ptr_t    ptr;
  logic [1:0] pick_gnt;
  logic [1:0] winner;
  logic       wait_armed;
  logic       ready_ok;
  logic       timeout;
  logic       err_flag;
  logic       timeout_hit;

  rr_pick2 u_pick (
    .req (({req1, req0})),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  // A ready seen during the first WAIT cycle may be left over from before the run.
  assign ready_ok    = wait_armed && mul_ready;
  assign timeout_hit = timeout && !ready_ok;

`ifdef MUL_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      wdog_cnt <= (state == ST_WAIT) ? wdog_cnt + 1'b1 : '0;
      if (state == ST_WAIT && next_state == ST_DONE)
        err_flag <= timeout_hit;
    end
  end

  assign timeout = (state == ST_WAIT) && (wdog_cnt == WDOG_LAST);
`else
  logic unused_wdog;
  assign unused_wdog = ^32'(WDOG_CYCLES);
  assign timeout     = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (|pick_gnt) next_state = ST_CLEAR;
      ST_CLEAR: next_state = ST_RUN;
      ST_RUN:   next_state = ST_WAIT;
      ST_WAIT:  if (ready_ok || timeout) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      winner     <= 2'b00;
      ptr        <= PTR_RESET;
      prod0      <= '0;
      prod1      <= '0;
      wait_armed <= 1'b0;
    end else begin
      wait_armed <= (state == ST_WAIT);
      if (state == ST_IDLE && (|pick_gnt)) begin
        winner <= pick_gnt;
        mul_a  <= pick_gnt[1] ? a1 : a0;
        mul_b  <= pick_gnt[1] ? b1 : b0;
      end
      // A timed-out operation reports a zero product to its requester.
      if (state == ST_WAIT && next_state == ST_DONE) begin
        if (winner[0]) prod0 <= timeout_hit ? '0 : mul_product;
        if (winner[1]) prod1 <= timeout_hit ? '0 : mul_product;
      end
      if (state == ST_DONE)
        ptr <= ptr_from_grant(winner);
    end
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    err0    = 1'b0;
    err1    = 1'b0;
    mul_clr = 1'b0;
    mul_run = 1'b0;
    busy    = (state != ST_IDLE);
    case (state)
      ST_CLEAR: begin
        gnt0    = winner[0];
        gnt1    = winner[1];
        mul_clr = 1'b1;
      end
      ST_RUN: mul_run = 1'b1;
      ST_DONE: begin
        done0 = winner[0];
        done1 = winner[1];
        err0  = winner[0] && err_flag;
        err1  = winner[1] && err_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter; the bench plays the shared multiplier.
module tb_mul_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [63:0] prod0, prod1;
  logic        mul_clr, mul_run, mul_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;

  int checks = 0;
  int errors = 0;

  mul_arbiter #(.DATA_W(32), .WDOG_CYCLES(40)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .prod0(prod0), .prod1(prod1), .err0(err0), .err1(err1),
    .busy(busy), .mul_clr(mul_clr), .mul_run(mul_run),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0: return gnt0;
      1: return gnt1;
      2: return mul_run;
      3: return done0;
      default: return done1;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (sig_of(which)) begin
        seen = 1;
        break;
      end
      step();
    end
  endtask

  // Called while in RUN (or later); delay >= 2 keeps ready out of the first WAIT cycle.
  task automatic pulse_ready(input logic [63:0] p, input int delay);
    repeat (delay) step();
    mul_ready   = 1'b1;
    mul_product = p;
    step();
    mul_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mul_ready = 1'b0; mul_product = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({gnt0, gnt1, done0, done1, err0, err1, busy, mul_clr, mul_run} !== 9'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b",
        {gnt0, gnt1, done0, done1, err0, err1, busy, mul_clr, mul_run}, 9'b0); end
    checks++; if ({mul_a, mul_b} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_mul_ops: got %h expected 0", {mul_a, mul_b}); end
    checks++; if ({prod0, prod1} !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_prod: got %h expected 0", {prod0, prod1}); end
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd6;
    step();
    checks++; if ({gnt0, gnt1, mul_clr} !== 3'b101) begin
      errors++; $display("[TB] FAIL single_gnt: got %b expected 101", {gnt0, gnt1, mul_clr}); end
    checks++; if ({mul_a, mul_b} !== {32'd7, 32'd6}) begin
      errors++; $display("[TB] FAIL single_ops: got %h expected %h", {mul_a, mul_b}, {32'd7, 32'd6}); end
    req0 = 1'b0; a0 = 32'hDEAD; b0 = 32'hBEEF;
    step();
    checks++; if ({mul_run, gnt0, mul_clr} !== 3'b100) begin
      errors++; $display("[TB] FAIL single_run: got %b expected 100", {mul_run, gnt0, mul_clr}); end
    pulse_ready(64'd42, 33);
    checks++; if ({done0, done1, err0} !== 3'b100) begin
      errors++; $display("[TB] FAIL single_done: got %b expected 100", {done0, done1, err0}); end
    checks++; if (prod0 !== 64'd42) begin
      errors++; $display("[TB] FAIL single_prod0: got %0d expected 42", prod0); end
    checks++; if ({mul_a, mul_b} !== {32'd7, 32'd6}) begin
      errors++; $display("[TB] FAIL single_ops_stable: got %h expected %h", {mul_a, mul_b}, {32'd7, 32'd6}); end
    step();
    checks++; if ({busy, done0} !== 2'b00) begin
      errors++; $display("[TB] FAIL single_idle: got %b expected 00", {busy, done0}); end
    checks++; if ({prod0, prod1} !== {64'd42, 64'd0}) begin
      errors++; $display("[TB] FAIL single_hold: got %h expected %h", {prod0, prod1}, {64'd42, 64'd0}); end
    seen = 0;
  endtask

  task automatic test_simultaneous();
    bit seen;
    do_reset();
    req0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
    req1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd2;
    step();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("[TB] FAIL simul_first_gnt: got %b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0;
    step();
    pulse_ready(64'd15, 3);
    checks++; if ({done0, done1, prod0} !== {2'b10, 64'd15}) begin
      errors++; $display("[TB] FAIL simul_done0: got %h expected %h", {done0, done1, prod0}, {2'b10, 64'd15}); end
    wait_sig(1, 6, seen);
    checks++; if (!seen) begin
      errors++; $display("[TB] FAIL simul_second_gnt: got timeout expected gnt1"); end
    checks++; if ({mul_a, mul_b, gnt0} !== {32'hFFFF_FFFF, 32'd2, 1'b0}) begin
      errors++; $display("[TB] FAIL simul_ops1: got %h expected %h", {mul_a, mul_b, gnt0}, {32'hFFFF_FFFF, 32'd2, 1'b0}); end
    req1 = 1'b0;
    step();
    pulse_ready(64'h1_FFFF_FFFE, 2);
    checks++; if ({done1, done0, prod1} !== {2'b10, 64'h1_FFFF_FFFE}) begin
      errors++; $display("[TB] FAIL simul_done1: got %h expected %h", {done1, done0, prod1}, {2'b10, 64'h1_FFFF_FFFE}); end
    checks++; if (prod0 !== 64'd15) begin
      errors++; $display("[TB] FAIL simul_prod0_kept: got %h expected f", prod0); end
  endtask

  task automatic test_fairness();
    bit seen;
    int who;
    logic [3:0] order;
    do_reset();
    req0 = 1'b1; a0 = 32'd2; b0 = 32'd3;
    req1 = 1'b1; a1 = 32'd4; b1 = 32'd5;
    order = '0;
    for (int op = 0; op < 4; op++) begin
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        if (gnt0 || gnt1) seen = 1;
        else step();
      end
      checks++; if (!seen) begin
        errors++; $display("[TB] FAIL fair_gnt_%0d: got timeout expected a grant", op); end
      who = gnt1 ? 1 : 0;
      order[op] = gnt1;
      if (op == 3) begin req0 = 1'b0; req1 = 1'b0; end
      step();
      pulse_ready(who == 1 ? 64'd20 : 64'd6, 2);
      checks++; if ((who == 1 ? {done1, prod1} : {done0, prod0}) !== {1'b1, (who == 1 ? 64'd20 : 64'd6)}) begin
        errors++; $display("[TB] FAIL fair_done_%0d: got done0=%b done1=%b expected requester %0d done", op, done0, done1, who); end
    end
    checks++; if (order !== 4'b1010) begin
      errors++; $display("[TB] FAIL fair_order: got %b expected 1010 (op3..op0)", order); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit done_seen;
    do_reset();
    req0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
    step();
    req0 = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    checks++; if ({busy, done0, gnt0, mul_run, mul_clr} !== 5'b0) begin
      errors++; $display("[TB] FAIL mid_rst_ctrl: got %b expected 00000", {busy, done0, gnt0, mul_run, mul_clr}); end
    checks++; if ({mul_a, mul_b, prod0} !== 128'h0) begin
      errors++; $display("[TB] FAIL mid_rst_data: got %h expected 0", {mul_a, mul_b, prod0}); end
    mul_ready = 1'b1; mul_product = 64'd81;
    done_seen = 0;
    repeat (3) begin step(); if (done0 || done1) done_seen = 1; end
    mul_ready = 1'b0;
    rst = 1'b1;
    repeat (3) begin step(); if (done0 || done1) done_seen = 1; end
    checks++; if (done_seen) begin
      errors++; $display("[TB] FAIL mid_no_done: got done expected none"); end
    req1 = 1'b1; a1 = 32'd11; b1 = 32'd12;
    step();
    checks++; if ({gnt1, gnt0} !== 2'b10) begin
      errors++; $display("[TB] FAIL mid_gnt1: got %b expected 10", {gnt1, gnt0}); end
    req1 = 1'b0;
    step();
    pulse_ready(64'd132, 2);
    checks++; if ({done1, prod1, prod0} !== {1'b1, 64'd132, 64'd0}) begin
      errors++; $display("[TB] FAIL mid_done1: got %h expected %h", {done1, prod1, prod0}, {1'b1, 64'd132, 64'd0}); end
    seen = 0;
  endtask

  task automatic test_stale_ready();
    do_reset();
    mul_ready = 1'b1; mul_product = 64'd99;
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
    step();
    req0 = 1'b0;
    step(); step(); step();
    checks++; if ({done0, busy} !== 2'b01) begin
      errors++; $display("[TB] FAIL stale_ignored: got %b expected 01", {done0, busy}); end
    mul_ready = 1'b0;
    step();
    checks++; if ({done0, prod0} !== {1'b0, 64'd0}) begin
      errors++; $display("[TB] FAIL stale_still_wait: got %h expected 0", {done0, prod0}); end
    mul_ready = 1'b1; mul_product = 64'd25;
    step();
    mul_ready = 1'b0;
    checks++; if ({done0, prod0} !== {1'b1, 64'd25}) begin
      errors++; $display("[TB] FAIL stale_done: got %h expected %h", {done0, prod0}, {1'b1, 64'd25}); end
  endtask

  task automatic test_watchdog();
    bit seen;
    int cnt;
    do_reset();
    req0 = 1'b1; a0 = 32'd2; b0 = 32'd3;
    step();
    req0 = 1'b0;
    step();
    pulse_ready(64'd6, 2);
    step();
    req0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
    wait_sig(2, 6, seen);
    req0 = 1'b0;
    checks++; if (!seen) begin
      errors++; $display("[TB] FAIL wdog_run: got timeout expected mul_run"); end
    step();
`ifdef MUL_ARB_WATCHDOG_EN
    cnt = 0;
    while (!done0 && cnt < 100) begin step(); cnt++; end
    checks++; if (cnt !== 40) begin
      errors++; $display("[TB] FAIL wdog_cycles: got %0d expected 40", cnt); end
    checks++; if ({done0, err0, err1, prod0} !== {3'b110, 64'd0}) begin
      errors++; $display("[TB] FAIL wdog_err: got %h expected %h", {done0, err0, err1, prod0}, {3'b110, 64'd0}); end
`else
    seen = 0;
    cnt = 0;
    repeat (60) begin step(); if (done0 || err0) seen = 1; end
    checks++; if ({busy, seen} !== 2'b10) begin
      errors++; $display("[TB] FAIL wdog_off_waits: got %b expected 10", {busy, seen}); end
    checks++; if (prod0 !== 64'd6) begin
      errors++; $display("[TB] FAIL wdog_off_prod0: got %0d expected 6 (cnt %0d)", prod0, cnt); end
`endif
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mul_ready = 1'b0; mul_product = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_stale_ready();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; product width is 2*DATA_W.
REQ-002 SHALL have parameter WDOG_CYCLES, default 40, maximum cycles allowed in WAIT before timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  request level per requester.
REQ-006 SHALL have ports a0/a1, b0/b1  input  DATA_W  multiplicand/multiplier per requester, stable while reqk=1.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: operands captured.
REQ-008 SHALL have ports done0/done1  output  1  one-cycle pulse: product valid.
REQ-009 SHALL have ports prod0/prod1  output  2*DATA_W  last product per requester, held until that port's next done.
REQ-010 SHALL have ports err0/err1  output  1  asserted with donek when the operation timed out.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports mul_clr, mul_run  output  1  active-high multiplier control reset pulse and start pulse.
REQ-013 SHALL have ports mul_a, mul_b  output  DATA_W  latched operands to the shared multiplier.
REQ-014 SHALL have ports mul_ready  input  1, mul_product  input  2*DATA_W  multiplier completion and result.

Function
REQ-015 SHALL implement FSM IDLE -> CLEAR -> RUN -> WAIT -> DONE -> IDLE, one state per cycle, except WAIT, which lasts until exit.
REQ-016 In IDLE with any reqk=1, SHALL select a winner, latch its operands into mul_a/mul_b, and enter CLEAR.
REQ-017 Arbitration SHALL be 2-way round-robin: with both requests pending, the requester not served last wins; with one request pending, that requester wins.
REQ-018 In CLEAR: gntk=1 for the winner and mul_clr=1; in RUN: mul_run=1; both pulses SHALL last exactly one cycle.
REQ-019 mul_a/mul_b SHALL remain stable from CLEAR through DONE; requester operands may change after gntk.
REQ-020 WAIT SHALL ignore mul_ready in its first cycle, exit on mul_ready=1, and latch mul_product into the winner's prodk.
REQ-021 In DONE: donek=1 and errk per REQ-028, prodk valid, round-robin pointer updated to the winner.
REQ-022 Latency: req sampled in IDLE at cycle N -> gnt at N+1, mul_run at N+2; mul_ready seen at M -> done at M+1, IDLE at M+2.
REQ-023 A reqk still high in the cycle after donek SHALL be treated as a new request.
REQ-024 Outputs of the non-winning port SHALL be unaffected by an operation.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, with gnt*/done*/err*/busy/mul_clr/mul_run=0, mul_a/mul_b=0, prod0/prod1=0, and the pointer favouring requester 0.
REQ-026 Reset mid-operation SHALL abandon the operation without generating donek.

Configuration
REQ-027 Macro MUL_ARB_WATCHDOG_EN SHALL compile in a WAIT-state cycle counter.
REQ-028 With the macro defined, after WDOG_CYCLES WAIT cycles without mul_ready, SHALL enter DONE with errk=1 and prodk=0; without it, WAIT SHALL wait indefinitely and err0/err1 SHALL be tied to 0.

Structure
REQ-029 Package mul_arb_pkg SHALL hold the FSM state enum, the default DATA_W constant, and the pointer encoding.
REQ-030 A sub-module rr_pick2 (2-way round-robin picker: req[1:0], ptr -> one-hot grant) SHALL be used.

Verification
REQ-031 Single request: req0=1, a0=7, b0=6, multiplier ready 33 cycles after run -> gnt0 at N+1, done0 with prod0=42, busy low two cycles after ready.
REQ-032 Simultaneous requests: req0=req1=1 after reset, a0=3/b0=5, a1=0xFFFFFFFF/b1=2 -> requester 0 served first (15), then requester 1 (0x1_FFFFFFFE).
REQ-033 Fairness: req0 and req1 held high for 4 operations -> grants alternate 0,1,0,1.
REQ-034 Reset mid-operation: rst low during WAIT -> no done, all outputs 0; the next req1 is granted normally.
REQ-035 Watchdog (macro defined, WDOG_CYCLES=40): mul_ready held 0 -> done0 and err0 exactly 40 WAIT cycles later with prod0=0; without the macro, busy stays high.
REQ-036 Stale ready: mul_ready=1 before CLEAR -> it is ignored, and the product is latched only on the post-run ready.
